// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// Host-side SPI frame generator. Takes one 10-bit command per handshake and
// sends it as one SPI frame, one bit per clk. There is no separate SCK.
// For read-data commands (opcode 11) it waits RD_WAIT idle cycles, then
// collects an 8-bit reply from MISO, MSB first. The reply is returned on
// rsp_data with a one-cycle rsp_valid pulse.
//
// MOSI, SS_n, rsp_valid and rsp_data are registered. Their next values are
// decoded from the *next* state, so each registered output lines up with the
// state it belongs to in the same cycle.
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
   parameter int unsigned RD_WAIT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [9:0] cmd_word,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       MOSI,
   output logic       SS_n,
   input  logic       MISO
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_SEL   = 3'd2;
   localparam logic [2:0] ST_SHIFT = 3'd3;
   localparam logic [2:0] ST_WAIT  = 3'd4;
   localparam logic [2:0] ST_RECV  = 3'd5;
   localparam logic [2:0] ST_END   = 3'd6;

   // Value of the counter on the last WAIT cycle. The WAIT state is never
   // entered when RD_WAIT is 0, so the value used in that case does not matter.
   localparam logic [3:0] WAIT_LAST = (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);

   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;            // bit / wait / reply-bit counter
   logic [9:0] sh_q, sh_d;              // outgoing command, MSB at [9]
   logic       rd_q, rd_d;              // current frame is read-data
   logic [7:0] rx_q, rx_d;              // reply being assembled
   logic       mosi_q, mosi_d;
   logic       ss_n_q, ss_n_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_data_q, rsp_data_d;

   // Next-state logic and the next values of the registered outputs
   always_comb begin
      // NOTE: every signal gets a default first, so no branch can leave one
      // unassigned. An unassigned branch would infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      rd_d        = rd_q;
      rx_d        = rx_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               sh_d    = cmd_word;
               rd_d    = (cmd_word[9:8] == 2'b11);
               state_d = ST_START;
            end
         end
         ST_START: state_d = ST_SEL;
         ST_SEL: begin
            // The selector bit (cmd_word[9]) goes out next. After that the
            // register shifts so the command itself follows it, MSB first.
            sh_d    = {sh_q[8:0], 1'b0};
            cnt_d   = 4'd0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            sh_d = {sh_q[8:0], 1'b0};
            if (cnt_q == 4'd9) begin
               cnt_d = 4'd0;
               if (!rd_q)             state_d = ST_END;
               else if (RD_WAIT == 0) state_d = ST_RECV;
               else                   state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = 4'd0;
               state_d = ST_RECV;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RECV: begin
            rx_d = {rx_q[6:0], MISO};
            if (cnt_q == 4'd7) begin
               rsp_data_d  = {rx_q[6:0], MISO};
               rsp_valid_d = 1'b1;
               state_d     = ST_END;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_END:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      ss_n_d = (state_d == ST_IDLE) || (state_d == ST_END);
      mosi_d = ((state_d == ST_SEL) || (state_d == ST_SHIFT)) ? sh_q[9] : 1'b0;
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples values from before this clock edge.
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         sh_q        <= 10'd0;
         rd_q        <= 1'b0;
         rx_q        <= 8'd0;
         mosi_q      <= 1'b0;
         ss_n_q      <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         rd_q        <= rd_d;
         rx_q        <= rx_d;
         mosi_q      <= mosi_d;
         ss_n_q      <= ss_n_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign MOSI      = mosi_q;
   assign SS_n      = ss_n_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
// Two instances: RD_WAIT=2 (index 0) and RD_WAIT=0 (index 1). For each frame,
// the expected waveform is computed cycle by cycle from the frame timing rules,
// counting from the handshake cycle (cycle 0).
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [1:0] cmd_valid, cmd_ready, rsp_valid, busy, mosi, ss_n, miso;
   logic [9:0] cmd_word [2];
   logic [7:0] rsp_data [2];
   logic [7:0] exp_rsp  [2];

   int n_tests = 0;
   int n_fail  = 0;

   spi_master_ctrl #(.RD_WAIT(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_word(cmd_word[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
      .busy(busy[0]), .MOSI(mosi[0]), .SS_n(ss_n[0]), .MISO(miso[0])
   );

   spi_master_ctrl #(.RD_WAIT(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_word(cmd_word[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
      .busy(busy[1]), .MOSI(mosi[1]), .SS_n(ss_n[1]), .MISO(miso[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int wait_of(input int inst);
      return (inst == 0) ? 2 : 0;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input int inst, input string ctx);
      check($sformatf("%s i%0d ss_n", ctx, inst), 32'(ss_n[inst]), 32'd1);
      check($sformatf("%s i%0d mosi", ctx, inst), 32'(mosi[inst]), 32'd0);
      check($sformatf("%s i%0d busy", ctx, inst), 32'(busy[inst]), 32'd0);
      check($sformatf("%s i%0d ready", ctx, inst), 32'(cmd_ready[inst]), 32'd1);
      check($sformatf("%s i%0d rsp_valid", ctx, inst), 32'(rsp_valid[inst]), 32'd0);
      check($sformatf("%s i%0d rsp_data", ctx, inst), 32'(rsp_data[inst]), 32'h00);
   endtask

   // Runs one frame on instance inst, starting in the current cycle (cycle 0).
   // hold: keep cmd_valid high with next_word after the accept.
   // pulse_at: cycle where a stray 1-cycle cmd_valid is offered (-1: none).
   // rst_at: cycle where rst_n is pulled low for one cycle (-1: none).
   // The task returns positioned on the cycle after END, or on the cycle
   // after the reset.
   task automatic run_frame(input int inst, input logic [9:0] cmd, input logic [7:0] reply,
                            input bit hold, input logic [9:0] next_word,
                            input int pulse_at, input int rst_at);
      bit rd;
      int w, last, rx0, low_last;
      rd       = (cmd[9:8] == 2'b11);
      w        = wait_of(inst);
      last     = rd ? 21 + w : 13;
      rx0      = 13 + w;
      low_last = rd ? 20 + w : 12;
      for (int k = 0; k <= last + 1; k++) begin
         logic ss_exp, mosi_exp, rv_exp, in_frame;
         string ctx;
         ctx = $sformatf("i%0d cmd%03h c%0d", inst, cmd, k);
         // drive inputs for this cycle
         if (k == 0) begin
            cmd_valid[inst] = 1'b1; cmd_word[inst] = cmd;
         end else if (k == pulse_at) begin
            cmd_valid[inst] = 1'b1; cmd_word[inst] = ~cmd;
         end else if (hold) begin
            cmd_valid[inst] = 1'b1; cmd_word[inst] = next_word;
         end else begin
            cmd_valid[inst] = 1'b0; cmd_word[inst] = 10'($urandom);
         end
         miso[inst] = (rd && k >= rx0 && k < rx0 + 8) ? reply[7 - (k - rx0)] : 1'($urandom);
         rst_n = (k == rst_at) ? 1'b0 : 1'b1;
         cmd_valid[1 - inst] = (k == rst_at);
         cmd_word[1 - inst]  = 10'h3FF;

         // the cycle right after a reset: both instances back to the reset state
         if (rst_at >= 0 && k == rst_at + 1) begin
            exp_rsp[0] = 8'h00;
            exp_rsp[1] = 8'h00;
            check_reset_state(inst, "post-reset");
            check_reset_state(1 - inst, "post-reset other");
            cmd_valid = 2'b00;
            rst_n     = 1'b1;
            return;
         end

         in_frame = (k >= 1 && k <= last);
         ss_exp   = !(k >= 1 && k <= low_last);
         if (k == 2)                mosi_exp = cmd[9];
         else if (k >= 3 && k <= 12) mosi_exp = cmd[12 - k];
         else                       mosi_exp = 1'b0;
         rv_exp = rd && (k == last);
         if (rv_exp) exp_rsp[inst] = reply;

         check({ctx, " ss_n"}, 32'(ss_n[inst]), 32'(ss_exp));
         check({ctx, " mosi"}, 32'(mosi[inst]), 32'(mosi_exp));
         check({ctx, " rsp_valid"}, 32'(rsp_valid[inst]), 32'(rv_exp));
         check({ctx, " busy"}, 32'(busy[inst]), 32'(in_frame));
         check({ctx, " ready"}, 32'(cmd_ready[inst]), 32'(!in_frame));
         check({ctx, " rsp_data"}, 32'(rsp_data[inst]), 32'(exp_rsp[inst]));

         if (k <= last) next_cycle();
      end
   endtask

   task automatic idle_cycles(input int inst, input int n);
      for (int i = 0; i < n; i++) begin
         cmd_valid[inst] = 1'b0;
         next_cycle();
         check($sformatf("idle i%0d busy", inst), 32'(busy[inst]), 32'd0);
         check($sformatf("idle i%0d ss_n", inst), 32'(ss_n[inst]), 32'd1);
         check($sformatf("idle i%0d rsp_valid", inst), 32'(rsp_valid[inst]), 32'd0);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      cmd_valid   = 2'b00;
      miso        = 2'b00;
      cmd_word[0] = 10'd0;
      cmd_word[1] = 10'd0;
      exp_rsp[0]  = 8'h00;
      exp_rsp[1]  = 8'h00;

      // reset, with a command offered on instance 0 that must not be taken
      repeat (2) next_cycle();
      cmd_valid[0] = 1'b1;
      cmd_word[0]  = 10'h3FF;
      next_cycle();
      check_reset_state(0, "reset");
      check_reset_state(1, "reset");
      cmd_valid = 2'b00;
      rst_n     = 1'b1;
      next_cycle();
      check_reset_state(0, "after reset");

      // write-addr 0A5
      run_frame(0, 10'h0A5, 8'h00, 1'b0, 10'h000, -1, -1);
      // read-data 3FF, reply C3
      run_frame(0, 10'h3FF, 8'hC3, 1'b0, 10'h000, -1, -1);
      // back-to-back write-data then read-addr, cmd_valid held high
      run_frame(0, 10'h15A, 8'h00, 1'b1, 10'h277, -1, -1);
      run_frame(0, 10'h277, 8'h00, 1'b0, 10'h000, -1, -1);
      // reset during SHIFT bit 5 (cycle 8) of a read-data frame, then a write frame
      run_frame(0, 10'h3C1, 8'hAA, 1'b0, 10'h000, -1, 8);
      run_frame(0, 10'h0F0, 8'h00, 1'b0, 10'h000, -1, -1);
      // RD_WAIT=0 read-data, reply 5A
      run_frame(1, 10'h312, 8'h5A, 1'b0, 10'h000, -1, -1);
      // stray cmd_valid pulse in the middle of a frame
      run_frame(0, 10'h1B4, 8'h00, 1'b0, 10'h000, 5, -1);
      idle_cycles(0, 3);

      // randomized frames
      for (int i = 0; i < 24; i++) begin
         int          inst, pulse;
         logic [9:0]  cmd;
         logic [7:0]  reply;
         inst  = int'($urandom_range(0, 1));
         cmd   = 10'($urandom);
         if ($urandom_range(0, 1) == 1) cmd[9:8] = 2'b11;
         reply = 8'($urandom);
         pulse = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : -1;
         run_frame(inst, cmd, reply, 1'b0, 10'h000, pulse, -1);
         if ($urandom_range(0, 1) == 1) idle_cycles(inst, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
